morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side companion to the Morse LED transmitter. It consumes the one-bit on/off stream that the transmitter drives onto LEDR[0], one unit per shifted bit. It measures mark and space run lengths in clock cycles, classifies each mark as dot or dash, and detects the inter-letter gap. At each gap it reports the decoded symbol pattern and which of the eight lab letters S–Z it matches, so a loopback bench or a second board can confirm what was sent.

## Interface
- UNIT_CYCLES, default 25000000: clock cycles per Morse unit. This is 0.5 s at 50 MHz, the transmitter's symbol period. Benches use 4.
- clock  in  1  system clock, CLOCK_50; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- line_in  in  1  Morse stream, 1 = mark. It is in the clock domain already, so no synchronizer.
- letter_valid  out  1  one-cycle pulse; all fields below are valid in this cycle.
- letter_code  out  3  0..7 = S,T,U,V,W,X,Y,Z. Holds 0 when letter_match=0.
- letter_match  out  1  pattern matched a table entry.
- sym_count  out  3  symbols received, 0..4.
- sym_pattern  out  4  bit i = 1 when symbol i is a dash; symbol 0 is the first sent. Unused bits are 0.
- error  out  1  more than 4 marks were received in the letter.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE, run counter 0, symbol count 0, pattern 0, overflow flag 0.
- Run counter: width $clog2(4*UNIT_CYCLES+1). It saturates at 4*UNIT_CYCLES and never wraps.
- IDLE:
  - line_in=1 → MARK, counter=1.
  - line_in=0 → stay.
- MARK:
  - line_in=1 → counter+1, saturating.
  - line_in=0 → classify the mark and go to SPACE with counter=1.
  - Classification: dash if counter ≥ 2*UNIT_CYCLES, else dot.
  - Appending a symbol when count<4: write the symbol bit at index sym_count, then sym_count+1.
  - Appending a symbol when count=4: set the overflow flag; pattern and count are unchanged.
- SPACE:
  - line_in=1 → MARK, counter=1. This is an intra-letter gap of any length below 3 units.
  - line_in=0 → counter+1. When the counter reaches 3*UNIT_CYCLES, emit the letter and go to IDLE.
- Emit:
  - Register the outputs and assert letter_valid for exactly one cycle.
  - Clear the internal count, pattern and overflow flag for the next letter.
  - Outputs hold their values until the next emit.
- Match table:
  - Exact (count, pattern) compare against the eight letters: S ..., T -, U ..-, V ...-, W .--, X -..-, Y -.--, Z --.. .
  - When overflow is set: error=1, letter_match=0, letter_code=0, sym_count=4.
- A mark still in progress never emits. A stream stuck high stays in MARK with a saturated counter.
- resetn=0 in any state, including mid-letter, discards the partial letter on that edge. No emit is produced.

## Timing
- Mark classification occurs on the edge where line_in is first sampled 0.
- letter_valid rises on the edge where the SPACE counter transitions to 3*UNIT_CYCLES. That is the 3*UNIT_CYCLES-th consecutive low sample after the last mark.
- The output fields and letter_valid update on the same edge; there is no extra pipeline stage.
- Boundary cases (UNIT_CYCLES=4):
  - 7-cycle mark → dot; 8-cycle mark → dash.
  - 11 lows then high → same letter; 12 lows → emit.
- A high sampled on the same edge the counter would reach 3*UNIT_CYCLES has priority: go to MARK, no emit.
- Throughput: one letter per gap. There is no backpressure, and letter_valid is not held.

## Structure
- Package morse_pkg holds:
  - the LETTER_S..LETTER_Z 3-bit codes;
  - the 8-entry table of {count, pattern} constants;
  - the state encoding IDLE/MARK/SPACE.
- The transmitter's letter mux should also source from this table.
- One sub-module, morse_run_counter, provides the saturating run-length counter with clear/load-1 and increment. The FSM, classifier and match logic stay in morse_decoder.

## Test plan
All scenarios use UNIT_CYCLES=4.
- Reset: hold resetn=0 for 3 cycles with line_in toggling → all outputs 0, no letter_valid.
- S: three 4-cycle marks with 4-cycle gaps, then 12 lows → single letter_valid pulse with code 0, match 1, count 3, pattern 4'b0000, error 0.
- Y: 12/4/12/12-cycle marks with 4-cycle gaps, then 12 lows → code 6, count 4, pattern 4'b1101, match 1.
- Thresholds:
  - a 7-cycle mark then 12 lows → count 1, pattern 0, match 0 (E is not in the table);
  - an 8-cycle mark → T, code 1;
  - an 11-low gap between two dots → one letter with count 2.
- Overflow: five dots then 12 lows → error 1, match 0, count 4, code 0; the next letter S decodes clean with error 0.
- Reset mid-letter: two dots, resetn low for 1 cycle, then a full T → only one letter_valid, code 1, count 1.

Source files
------------

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morse_pkg
//  Purpose  : Shared Morse definitions. It holds the letter codes, the S..Z
//             pattern table, the FSM states and the run-counter operations.
//  Revision : 1.0  initial release
// ============================================================================
package morse_pkg;

    localparam logic [2:0] LETTER_S = 3'd0;
    localparam logic [2:0] LETTER_T = 3'd1;
    localparam logic [2:0] LETTER_U = 3'd2;
    localparam logic [2:0] LETTER_V = 3'd3;
    localparam logic [2:0] LETTER_W = 3'd4;
    localparam logic [2:0] LETTER_X = 3'd5;
    localparam logic [2:0] LETTER_Y = 3'd6;
    localparam logic [2:0] LETTER_Z = 3'd7;

    // Bit i of pattern is 1 when symbol i (first sent = 0) is a dash.
    typedef struct packed {
        logic [2:0] count;
        logic [3:0] pattern;
    } letter_entry_t;

    // Indexed by letter code. The transmitter's letter mux reads the same table.
    localparam letter_entry_t LETTER_TABLE [0:7] = '{
        '{count: 3'd3, pattern: 4'b0000},   // S ...
        '{count: 3'd1, pattern: 4'b0001},   // T -
        '{count: 3'd3, pattern: 4'b0100},   // U ..-
        '{count: 3'd4, pattern: 4'b1000},   // V ...-
        '{count: 3'd3, pattern: 4'b0110},   // W .--
        '{count: 3'd4, pattern: 4'b1001},   // X -..-
        '{count: 3'd4, pattern: 4'b1101},   // Y -.--
        '{count: 3'd4, pattern: 4'b0011}    // Z --..
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CTR_HOLD  = 2'd0,
        CTR_CLEAR = 2'd1,
        CTR_LOAD1 = 2'd2,
        CTR_INC   = 2'd3
    } ctr_op_e;

    // Returns {hit, code}. The code is 0 when no entry matches.
    function automatic logic [3:0] match_letter(input logic [2:0] cnt,
                                                input logic [3:0] pat);
        logic [3:0] result;
        result = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            if (!result[3] && LETTER_TABLE[k].count == cnt &&
                LETTER_TABLE[k].pattern == pat) begin
                result = {1'b1, 3'(k)};
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : morse_decoder_if
//  Purpose  : Line input and decoded-letter outputs of the Morse decoder.
//             The master side drives the line. The slave side is the decoder.
//  Revision : 1.0  initial release
// ============================================================================
interface morse_decoder_if;
    logic       line_in;
    logic       letter_valid;
    logic [2:0] letter_code;
    logic       letter_match;
    logic [2:0] sym_count;
    logic [3:0] sym_pattern;
    logic       error;

    modport master (
        output line_in,
        input  letter_valid, letter_code, letter_match,
               sym_count, sym_pattern, error
    );

    modport slave (
        input  line_in,
        output letter_valid, letter_code, letter_match,
               sym_count, sym_pattern, error
    );
endinterface
`default_nettype wire

// File: rtl/morse_run_counter.sv
`default_nettype none
// ============================================================================
//  Module   : morse_run_counter
//  Purpose  : Saturating run-length counter. It supports clear, load-one and
//             increment operations and never wraps past MAX_COUNT.
//  Revision : 1.0  initial release
// ============================================================================
module morse_run_counter
    import morse_pkg::*;
#(
    parameter int MAX_COUNT = 16,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  wire logic             clock,
    input  wire logic             resetn,
    input  wire ctr_op_e          op,
    output logic      [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_count;

    // Apply the requested operation. Increment holds once the limit is reached.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            case (op)
                CTR_CLEAR: r_count <= '0;
                CTR_LOAD1: r_count <= WIDTH'(1);
                CTR_INC:   if (r_count != c_max) r_count <= r_count + WIDTH'(1);
                default:   r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_decoder
//  Purpose  : Measures mark/space runs on a Morse line. It classifies marks as
//             dot or dash and reports each letter at the inter-letter gap.
//  Revision : 1.0  initial release
// ============================================================================
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000
) (
    input  wire logic     clock,
    input  wire logic     resetn,
    morse_decoder_if.slave bus
);

    localparam int               c_max_run  = 4 * UNIT_CYCLES;
    localparam int               c_width    = $clog2(c_max_run + 1);
    localparam logic [c_width-1:0] c_dash_min = c_width'(2 * UNIT_CYCLES);
    // Counter value on the edge before the gap is complete.
    localparam logic [c_width-1:0] c_gap_last = c_width'(3 * UNIT_CYCLES - 1);

    state_e             r_state;
    logic [2:0]         r_acc_count;
    logic [3:0]         r_acc_pattern;
    logic               r_overflow;

    logic               r_letter_valid;
    logic [2:0]         r_letter_code;
    logic               r_letter_match;
    logic [2:0]         r_sym_count;
    logic [3:0]         r_sym_pattern;
    logic               r_error;

    logic [c_width-1:0] w_run;
    ctr_op_e            w_ctr_op;
    logic               w_emit;
    logic               w_is_dash;
    logic [3:0]         w_lookup;

    morse_run_counter #(
        .MAX_COUNT (c_max_run),
        .WIDTH     (c_width)
    ) u_run_counter (
        .clock  (clock),
        .resetn (resetn),
        .op     (w_ctr_op),
        .count  (w_run)
    );

    assign w_emit    = (r_state == SPACE) && !bus.line_in && (w_run == c_gap_last);
    assign w_is_dash = (w_run >= c_dash_min);
    assign w_lookup  = match_letter(r_acc_count, r_acc_pattern);

    // Choose the run-counter operation. Every line transition restarts the count at 1.
    always_comb begin
        w_ctr_op = CTR_HOLD;
        case (r_state)
            IDLE:    w_ctr_op = bus.line_in ? CTR_LOAD1 : CTR_HOLD;
            MARK:    w_ctr_op = bus.line_in ? CTR_INC   : CTR_LOAD1;
            SPACE:   w_ctr_op = bus.line_in ? CTR_LOAD1 : (w_emit ? CTR_CLEAR : CTR_INC);
            default: w_ctr_op = CTR_CLEAR;
        endcase
    end

    // Letter FSM. It accumulates symbols and registers the decoded outputs at the gap.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state        <= IDLE;
            r_acc_count    <= 3'd0;
            r_acc_pattern  <= 4'd0;
            r_overflow     <= 1'b0;
            r_letter_valid <= 1'b0;
            r_letter_code  <= 3'd0;
            r_letter_match <= 1'b0;
            r_sym_count    <= 3'd0;
            r_sym_pattern  <= 4'd0;
            r_error        <= 1'b0;
        end else begin
            r_letter_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.line_in) r_state <= MARK;
                end
                MARK: begin
                    if (!bus.line_in) begin
                        r_state <= SPACE;
                        if (r_acc_count == 3'd4) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_acc_pattern[r_acc_count[1:0]] <= w_is_dash;
                            r_acc_count <= r_acc_count + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    if (bus.line_in) begin
                        r_state <= MARK;
                    end else if (w_emit) begin
                        r_state        <= IDLE;
                        r_letter_valid <= 1'b1;
                        r_sym_count    <= r_acc_count;
                        r_sym_pattern  <= r_acc_pattern;
                        r_error        <= r_overflow;
                        r_letter_match <= r_overflow ? 1'b0 : w_lookup[3];
                        r_letter_code  <= r_overflow ? 3'd0 : w_lookup[2:0];
                        r_acc_count    <= 3'd0;
                        r_acc_pattern  <= 4'd0;
                        r_overflow     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.letter_valid = r_letter_valid;
    assign bus.letter_code  = r_letter_code;
    assign bus.letter_match = r_letter_match;
    assign bus.sym_count    = r_sym_count;
    assign bus.sym_pattern  = r_sym_pattern;
    assign bus.error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_decoder
//  Purpose  : Self-checking bench for morse_decoder with UNIT_CYCLES = 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_decoder;

    localparam int U = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    morse_decoder_if bus ();

    morse_decoder #(.UNIT_CYCLES(U)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model -----------------------------------
    // The model keeps the run of lows since the last mark and the list of
    // dot/dash symbols. The letter is decoded by matching a dot-dash string.
    string tbl [8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    bit    syms [$];
    bit    in_mark  = 1'b0;
    int    mark_len = 0;
    int    lows     = 0;
    string s;

    logic       e_valid = 0, e_match = 0, e_err = 0;
    logic [2:0] e_code  = 0, e_cnt = 0;
    logic [3:0] e_pat   = 0;

    int         pulses = 0;
    logic [2:0] l_code, l_cnt;
    logic [3:0] l_pat;
    logic       l_match, l_err;

    always begin
        @(posedge clock);
        if (!resetn) begin
            syms.delete();
            in_mark = 0; mark_len = 0; lows = 0;
            {e_valid, e_match, e_err, e_code, e_cnt, e_pat} = '0;
        end else begin
            e_valid = 0;
            if (bus.line_in) begin
                if (!in_mark) begin in_mark = 1; mark_len = 1; end
                else mark_len++;
            end else if (in_mark) begin
                in_mark = 0;
                syms.push_back(mark_len >= 2 * U);
                lows = 1;
            end else begin
                lows++;
                if (lows == 3 * U && syms.size() > 0) begin
                    s = "";
                    e_pat = 0;
                    for (int i = 0; i < syms.size() && i < 4; i++) begin
                        s = {s, syms[i] ? "-" : "."};
                        e_pat[i] = syms[i];
                    end
                    e_valid = 1;
                    e_err   = syms.size() > 4;
                    e_cnt   = (syms.size() > 4) ? 3'd4 : 3'(syms.size());
                    e_match = 0;
                    e_code  = 0;
                    if (!e_err)
                        for (int k = 0; k < 8; k++)
                            if (tbl[k] == s) begin e_match = 1; e_code = 3'(k); end
                    syms.delete();
                end
            end
        end
        #1;
        check("valid", bus.letter_valid, e_valid);
        check("code",  bus.letter_code,  e_code);
        check("match", bus.letter_match, e_match);
        check("count", bus.sym_count,    e_cnt);
        check("pattern", bus.sym_pattern, e_pat);
        check("error", bus.error,        e_err);
        if (bus.letter_valid === 1'b1) begin
            pulses++;
            l_code = bus.letter_code; l_cnt = bus.sym_count; l_pat = bus.sym_pattern;
            l_match = bus.letter_match; l_err = bus.error;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic drive(input logic v, input int n);
        bus.line_in = v;
        repeat (n) @(negedge clock);
    endtask

    // Sends the marks with 4-cycle gaps between them, then a 12-low letter gap.
    task automatic send(input int m0, input int m1, input int m2, input int m3, input int m4);
        int m [5];
        m = '{m0, m1, m2, m3, m4};
        for (int i = 0; i < 5; i++) begin
            if (m[i] > 0) begin
                if (i > 0) drive(0, U);
                drive(1, m[i]);
            end
        end
        drive(0, 3 * U + 2);
    endtask

    // Checks the latched DUT letter against literals, and also the model against them.
    task automatic expect_letter(input string name, input int p0, input logic [2:0] code,
                                 input logic match, input logic [2:0] cnt,
                                 input logic [3:0] pat, input logic err);
        check({name, " pulses"}, pulses - p0, 1);
        check({name, " code"},  l_code,  code);
        check({name, " match"}, l_match, match);
        check({name, " count"}, l_cnt,   cnt);
        check({name, " pattern"}, l_pat, pat);
        check({name, " error"}, l_err,   err);
        check({name, " model code"},  e_code,  code);
        check({name, " model count"}, e_cnt,   cnt);
        check({name, " model pattern"}, e_pat, pat);
        check({name, " model match"}, e_match, match);
    endtask

    initial begin
        int p0;
        int n, gap;
        bus.line_in = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        // Reset with a toggling line.
        for (int i = 0; i < 3; i++) begin
            bus.line_in = i[0];
            @(negedge clock);
        end
        check("reset valid", bus.letter_valid, 0);
        check("reset code",  bus.letter_code,  0);
        check("reset count", bus.sym_count,    0);
        check("reset error", bus.error,        0);
        check("reset pulses", pulses, 0);
        resetn = 1'b1;
        drive(0, 5);

        p0 = pulses; send(4, 4, 4, 0, 0);    expect_letter("S", p0, 3'd0, 1, 3'd3, 4'b0000, 0);
        p0 = pulses; send(12, 4, 12, 12, 0); expect_letter("Y", p0, 3'd6, 1, 3'd4, 4'b1101, 0);
        p0 = pulses; send(7, 0, 0, 0, 0);    expect_letter("E7", p0, 3'd0, 0, 3'd1, 4'b0000, 0);
        p0 = pulses; send(8, 0, 0, 0, 0);    expect_letter("T8", p0, 3'd1, 1, 3'd1, 4'b0001, 0);

        // An 11-low gap stays inside the letter.
        p0 = pulses;
        drive(1, 4); drive(0, 11); drive(1, 4); drive(0, 3 * U + 2);
        expect_letter("gap11", p0, 3'd0, 0, 3'd2, 4'b0000, 0);

        // Five dots overflow the letter. The S that follows is clean.
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin drive(1, 4); drive(0, (i == 4) ? 3 * U + 2 : 4); end
        expect_letter("overflow", p0, 3'd0, 0, 3'd4, 4'b0000, 1);
        p0 = pulses; send(4, 4, 4, 0, 0);    expect_letter("S after ovf", p0, 3'd0, 1, 3'd3, 4'b0000, 0);

        // A reset mid-letter discards the partial letter.
        p0 = pulses;
        drive(1, 4); drive(0, 4); drive(1, 4); drive(0, 2);
        resetn = 1'b0; @(negedge clock); resetn = 1'b1;
        send(8, 0, 0, 0, 0);
        expect_letter("reset mid", p0, 3'd1, 1, 3'd1, 4'b0001, 0);

        // Randomized letters. The per-cycle compare against the model does the checking.
        for (int l = 0; l < 60; l++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    resetn = 1'b0;
                    repeat ($urandom_range(1, 2)) @(negedge clock);
                    resetn = 1'b1;
                end
                drive(1, $urandom_range(1, 20));
                gap = (i == n - 1) ? $urandom_range(3 * U, 3 * U + 8) : $urandom_range(1, 3 * U - 1);
                drive(0, gap);
            end
        end
        drive(0, 3 * U + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
